// File: rtl/risc_spm.sv
// risc_spm: 8-bit multicycle stored-program CPU with four general registers,
// PC/IR/MAR, a zero flag and a 256x8 unified program/data memory.

module RiscSpmRam (
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o
);
    logic [7:0] memory [0:255];

    assign rdata_o = memory[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) memory[addr_i] <= wdata_i;
    end
endmodule

module risc_spm (
    input logic clk,
    input logic rst
);
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_RD   = 4'h5;
    localparam logic [3:0] OP_WR   = 4'h6;
    localparam logic [3:0] OP_BR   = 4'h7;
    localparam logic [3:0] OP_BRZ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        IDLE, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] mar_q, mar_d;
    logic [7:0] r_q [4];
    logic [7:0] r_d [4];
    logic       z_q, z_d;

    logic [3:0] opcode;
    logic [1:0] dest;
    logic [1:0] src;
    logic [7:0] aluResult;
    logic [7:0] memRdata;
    logic       memWe;

    assign opcode = ir_q[7:4];
    assign dest   = ir_q[3:2];
    assign src    = ir_q[1:0];

    // A reset arriving during WR2 must win over the pending store.
    assign memWe = (state_q == WR2) && !rst;

    RiscSpmRam Ram (
        .clk_i   (clk),
        .we_i    (memWe),
        .addr_i  (mar_q),
        .wdata_i (r_q[src]),
        .rdata_o (memRdata)
    );

    always_comb begin
        aluResult = 8'h00;
        case (opcode)
            OP_ADD:  aluResult = r_q[dest] + r_q[src];
            OP_SUB:  aluResult = r_q[dest] - r_q[src];
            OP_AND:  aluResult = r_q[dest] & r_q[src];
            OP_NOT:  aluResult = ~r_q[src];
            default: aluResult = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mar_d   = mar_q;
        r_d     = r_q;
        z_d     = z_q;
        case (state_q)
            IDLE: state_d = FET1;
            FET1: begin
                mar_d   = pc_q;
                state_d = FET2;
            end
            FET2: begin
                ir_d    = memRdata;
                pc_d    = pc_q + 8'd1;
                state_d = DEC;
            end
            DEC: begin
                state_d = FET1;
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: state_d = EX1;
                    OP_RD: begin
                        mar_d   = pc_q;
                        state_d = RD1;
                    end
                    OP_WR: begin
                        mar_d   = pc_q;
                        state_d = WR1;
                    end
                    OP_BR: begin
                        mar_d   = pc_q;
                        state_d = BR1;
                    end
                    OP_BRZ: begin
                        if (z_q) begin
                            mar_d   = pc_q;
                            state_d = BR1;
                        end else begin
                            pc_d = pc_q + 8'd1;
                        end
                    end
                    OP_HALT: state_d = HALT;
                    default: state_d = FET1;
                endcase
            end
            EX1: begin
                r_d[dest] = aluResult;
                z_d       = (aluResult == 8'h00);
                state_d   = FET1;
            end
            RD1: begin
                mar_d   = memRdata;
                pc_d    = pc_q + 8'd1;
                state_d = RD2;
            end
            RD2: begin
                r_d[dest] = memRdata;
                state_d   = FET1;
            end
            WR1: begin
                mar_d   = memRdata;
                pc_d    = pc_q + 8'd1;
                state_d = WR2;
            end
            WR2: state_d = FET1;
            // Branch target is fetched indirectly through the address byte.
            BR1: begin
                mar_d   = memRdata;
                state_d = BR2;
            end
            BR2: begin
                pc_d    = memRdata;
                state_d = FET1;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            mar_q   <= 8'h00;
            r_q     <= '{default: 8'h00};
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            r_q     <= r_d;
            z_q     <= z_d;
        end
    end
endmodule

// File: tb/tb_risc_spm.sv
// tb_risc_spm: scoreboard bench for risc_spm; an instruction-level model predicts
// the architectural state at the cycle each instruction retires.

module tb_risc_spm;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks    = 0;
    int failures  = 0;
    int edgeCount = 0;

    logic [7:0] memImage [256];

    typedef struct packed {
        int          cycle;
        logic [7:0]  pc;
        logic [3:0][7:0] regs;
        logic        z;
        logic [7:0]  memAddr;
        logic [7:0]  memVal;
    } chk_t;

    chk_t sb[$];

    risc_spm dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) edgeCount <= 0;
        else     edgeCount <= edgeCount + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Monitor: pops a prediction when the DUT reaches that instruction's retire cycle.
    always @(negedge clk) begin
        chk_t c;
        while (!rst && sb.size() > 0 && sb[0].cycle <= edgeCount) begin
            c = sb.pop_front();
            checkOutput($sformatf("retire_cycle@%0d", c.cycle), edgeCount, c.cycle);
            checkOutput($sformatf("pc@%0d", c.cycle), int'(dut.pc_q), int'(c.pc));
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("r%0d@%0d", i, c.cycle), int'(dut.r_q[i]), int'(c.regs[i]));
            checkOutput($sformatf("z@%0d", c.cycle), int'(dut.z_q), int'(c.z));
            checkOutput($sformatf("mem[%0d]@%0d", c.memAddr, c.cycle),
                        int'(dut.Ram.memory[c.memAddr]), int'(c.memVal));
        end
    end

    task automatic loadMem();
        for (int i = 0; i < 256; i++) dut.Ram.memory[i] = memImage[i];
    endtask

    task automatic clearImage();
        for (int i = 0; i < 256; i++) memImage[i] = 8'h00;
    endtask

    task automatic holdReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Instruction-set model: walks the program, queues the expected state and retire
    // cycle of each instruction, then releases reset and waits for the monitor.
    task automatic applyStimulus(input int maxInstr, input int budget);
        logic [7:0] mm [256];
        logic [7:0] rr [4];
        logic [7:0] pc, op, a;
        logic       z;
        int         cyc, cost;
        bit         halted;
        chk_t       c;
        mm = memImage;
        for (int i = 0; i < 4; i++) rr[i] = 8'h00;
        pc = 8'h00; z = 1'b0; cyc = 1; halted = 1'b0;
        for (int k = 0; k < maxInstr && !halted; k++) begin
            op = mm[pc];
            pc = pc + 8'd1;
            cost = 3;
            c.memAddr = 8'($urandom_range(0, 255));
            case (op[7:4])
                4'h1: begin rr[op[3:2]] = rr[op[3:2]] + rr[op[1:0]]; z = (rr[op[3:2]] == 8'h00); cost = 4; end
                4'h2: begin rr[op[3:2]] = rr[op[3:2]] - rr[op[1:0]]; z = (rr[op[3:2]] == 8'h00); cost = 4; end
                4'h3: begin rr[op[3:2]] = rr[op[3:2]] & rr[op[1:0]]; z = (rr[op[3:2]] == 8'h00); cost = 4; end
                4'h4: begin rr[op[3:2]] = ~rr[op[1:0]];              z = (rr[op[3:2]] == 8'h00); cost = 4; end
                4'h5: begin a = mm[pc]; pc = pc + 8'd1; rr[op[3:2]] = mm[a]; cost = 5; end
                4'h6: begin a = mm[pc]; pc = pc + 8'd1; mm[a] = rr[op[1:0]]; c.memAddr = a; cost = 5; end
                4'h7: begin pc = mm[mm[pc]]; cost = 5; end
                4'h8: begin
                    if (z) begin pc = mm[mm[pc]]; cost = 5; end
                    else   pc = pc + 8'd1;
                end
                4'hF: halted = 1'b1;
                default: ;
            endcase
            cyc += cost;
            c.cycle = cyc;
            c.pc    = pc;
            for (int i = 0; i < 4; i++) c.regs[i] = rr[i];
            c.z      = z;
            c.memVal = mm[c.memAddr];
            sb.push_back(c);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < budget && sb.size() > 0; t++) @(negedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            checkOutput("retire_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        // Countdown: R1 counts 6 down by R0; R3 accumulates R2 on each pass.
        clearImage();
        memImage[0]  = 8'h00;
        memImage[1]  = 8'h58; memImage[2]  = 8'd130;
        memImage[3]  = 8'h5C; memImage[4]  = 8'd131;
        memImage[5]  = 8'h54; memImage[6]  = 8'd128;
        memImage[7]  = 8'h50; memImage[8]  = 8'd129;
        memImage[9]  = 8'h24;
        memImage[10] = 8'h80; memImage[11] = 8'd134;
        memImage[12] = 8'h1E;
        memImage[13] = 8'h73; memImage[14] = 8'd140;
        memImage[128] = 8'd6; memImage[129] = 8'd1; memImage[130] = 8'd2; memImage[131] = 8'd0;
        memImage[134] = 8'd139; memImage[139] = 8'hF0; memImage[140] = 8'd9;
        loadMem();
        repeat (2) @(negedge clk);
        checkOutput("reset_pc", int'(dut.pc_q), 0);
        checkOutput("reset_z", int'(dut.z_q), 0);

        applyStimulus(100, 300);
        checkOutput("cd_r0", int'(dut.r_q[0]), 1);
        checkOutput("cd_r1", int'(dut.r_q[1]), 0);
        checkOutput("cd_r2", int'(dut.r_q[2]), 2);
        checkOutput("cd_r3", int'(dut.r_q[3]), 10);
        checkOutput("cd_z", int'(dut.z_q), 1);
        checkOutput("cd_pc", int'(dut.pc_q), 140);

        repeat (60) @(negedge clk);
        checkOutput("halt_pc", int'(dut.pc_q), 140);
        checkOutput("halt_r3", int'(dut.r_q[3]), 10);
        checkOutput("halt_z", int'(dut.z_q), 1);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst2_pc", int'(dut.pc_q), 0);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("rst2_r%0d", i), int'(dut.r_q[i]), 0);
        checkOutput("rst2_z", int'(dut.z_q), 0);
        checkOutput("rst2_mem139", int'(dut.Ram.memory[139]), 8'hF0);
        checkOutput("rst2_mem130", int'(dut.Ram.memory[130]), 2);

        // ALU, flag, untaken BRZ, WR and dest==src program.
        clearImage();
        memImage[0]  = 8'h50; memImage[1]  = 8'hA0;
        memImage[2]  = 8'h54; memImage[3]  = 8'hA1;
        memImage[4]  = 8'h31;
        memImage[5]  = 8'h49;
        memImage[6]  = 8'h80; memImage[7]  = 8'hA5;
        memImage[8]  = 8'h50; memImage[9]  = 8'hA2;
        memImage[10] = 8'h54; memImage[11] = 8'hA3;
        memImage[12] = 8'h11;
        memImage[13] = 8'h5C; memImage[14] = 8'hA4;
        memImage[15] = 8'h63; memImage[16] = 8'd200;
        memImage[17] = 8'h25;
        memImage[18] = 8'hF0;
        memImage[8'hA0] = 8'h0F; memImage[8'hA1] = 8'hF0; memImage[8'hA2] = 8'hFF;
        memImage[8'hA3] = 8'h01; memImage[8'hA4] = 8'h5A; memImage[8'hA5] = 8'h30;
        loadMem();
        repeat (2) @(negedge clk);
        applyStimulus(20, 150);
        checkOutput("alu_r0", int'(dut.r_q[0]), 0);
        checkOutput("alu_r1", int'(dut.r_q[1]), 0);
        checkOutput("alu_r2", int'(dut.r_q[2]), 8'h0F);
        checkOutput("alu_r3", int'(dut.r_q[3]), 8'h5A);
        checkOutput("alu_z", int'(dut.z_q), 1);
        checkOutput("alu_pc", int'(dut.pc_q), 19);
        checkOutput("alu_mem200", int'(dut.Ram.memory[200]), 8'h5A);

        // Reset landing in WR2 must cancel the store.
        holdReset();
        clearImage();
        memImage[0] = 8'h63; memImage[1] = 8'd200; memImage[200] = 8'h11;
        loadMem();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("wr2_mar", int'(dut.mar_q), 200);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("wr2_mem200", int'(dut.Ram.memory[200]), 8'h11);
        checkOutput("wr2_pc", int'(dut.pc_q), 0);

        // All-NOP memory walks the PC across the 255 -> 0 wrap.
        holdReset();
        clearImage();
        loadMem();
        applyStimulus(260, 800);

        for (int p = 0; p < 8; p++) begin
            holdReset();
            for (int i = 0; i < 256; i++) memImage[i] = 8'($urandom_range(0, 255));
            loadMem();
            applyStimulus(40, 260);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
